// File: rtl/int_pipe_sequencer.sv
// Pipeline sequencer: merges load-use stall and branch redirect into
// PC/IF-ID/ID-EX control and runs the interrupt entry sequence.
module int_pipe_sequencer #(
  parameter int PC_WIDTH     = 32,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                HDU_stall_in,
  input  logic                branch_taken_EX_in,
  input  logic                int_req_in,
  input  logic                mem_busy_in,
  input  logic [PC_WIDTH-1:0] pc_ID_in,
  output logic                PC_write_en_out,
  output logic                IF_ID_en_out,
  output logic                IF_ID_flush_out,
  output logic                ID_EX_flush_out,
  output logic                push_pc_out,
  output logic                push_flags_out,
  output logic                load_vec_out,
  output logic [PC_WIDTH-1:0] ret_pc_out,
  output logic                int_busy_out,
  output logic                int_ack_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_PUSH_PC,
    S_PUSH_FLAGS,
    S_LOAD_VEC
  } state_t;

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

  state_t              r_state;
  logic                r_pending;
  logic                r_int_prev;
  logic [3:0]          r_cnt;
  logic [PC_WIDTH-1:0] r_ret_pc;

  logic w_edge;
  logic w_pend;
  logic w_idle;
  logic w_accept;

  assign w_edge   = int_req_in & ~r_int_prev;
  assign w_pend   = r_pending | w_edge;
  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = w_idle & w_pend
                  & ~HDU_stall_in & ~branch_taken_EX_in;

  assign ret_pc_out = r_ret_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pending  <= 1'b0;
      r_int_prev <= 1'b0;
      r_cnt      <= 4'd0;
      r_ret_pc   <= '0;
    end else begin
      r_int_prev <= int_req_in;
      // edges seen mid-sequence stay pending until the next acceptance
      r_pending  <= w_pend & ~w_accept;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_ret_pc <= pc_ID_in;
            r_cnt    <= DRAIN_INIT;
            r_state  <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (r_cnt == 4'd0) r_state <= S_PUSH_PC;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        S_PUSH_PC: begin
          if (!mem_busy_in) r_state <= S_PUSH_FLAGS;
        end
        S_PUSH_FLAGS: begin
          if (!mem_busy_in) r_state <= S_LOAD_VEC;
        end
        S_LOAD_VEC: r_state <= S_IDLE;
        default:    r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    PC_write_en_out = 1'b0;
    IF_ID_en_out    = 1'b1;
    IF_ID_flush_out = 1'b1;
    ID_EX_flush_out = 1'b1;
    push_pc_out     = 1'b0;
    push_flags_out  = 1'b0;
    load_vec_out    = 1'b0;
    int_busy_out    = 1'b0;
    int_ack_out     = 1'b0;
    if (rst) begin
      IF_ID_en_out = 1'b0;
    end else if (w_idle) begin
      if (!w_accept) begin
        PC_write_en_out = ~HDU_stall_in | branch_taken_EX_in;
        IF_ID_en_out    = ~HDU_stall_in;
        IF_ID_flush_out = branch_taken_EX_in;
        ID_EX_flush_out = HDU_stall_in | branch_taken_EX_in;
      end
    end else begin
      int_busy_out = 1'b1;
      unique case (r_state)
        S_PUSH_PC:    push_pc_out    = 1'b1;
        S_PUSH_FLAGS: push_flags_out = 1'b1;
        S_LOAD_VEC: begin
          load_vec_out    = 1'b1;
          PC_write_en_out = 1'b1;
          int_ack_out     = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_int_pipe_sequencer.sv
// Bench for int_pipe_sequencer: directed scenarios plus random traffic
// checked against a phase-queue reference model.
module tb_int_pipe_sequencer;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst, stall, br, req, mbusy;
  logic [31:0] pc;
  logic        pcw, en, f1, f2, ppc, pfl, lv, busy, ack;
  logic [31:0] ret;

  int tests = 0;
  int fails = 0;

  byte         m_q[$];
  logic        m_pend = 1'b0;
  logic        m_prev = 1'b0;
  logic [31:0] m_ret  = '0;

  int busy_cnt, ppc_cnt, lv_cnt;

  always #5 clk = ~clk;

  int_pipe_sequencer #(.PC_WIDTH(32), .DRAIN_CYCLES(N)) dut (
    .clk(clk), .rst(rst),
    .HDU_stall_in(stall), .branch_taken_EX_in(br),
    .int_req_in(req), .mem_busy_in(mbusy), .pc_ID_in(pc),
    .PC_write_en_out(pcw), .IF_ID_en_out(en),
    .IF_ID_flush_out(f1), .ID_EX_flush_out(f2),
    .push_pc_out(ppc), .push_flags_out(pfl),
    .load_vec_out(lv), .ret_pc_out(ret),
    .int_busy_out(busy), .int_ack_out(ack)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic step(input logic r, s, b, q, m,
                      input logic [31:0] p);
    logic [8:0] e;
    logic edg, pend, acc;
    byte ph;
    rst = r; stall = s; br = b; req = q; mbusy = m; pc = p;
    #3;
    edg  = q & ~m_prev;
    pend = m_pend | edg;
    acc  = (m_q.size() == 0) & pend & ~s & ~b;
    if (r)
      e = 9'b0_0_1_1_0_0_0_0_0;
    else if (m_q.size() == 0) begin
      if (acc) e = 9'b0_1_1_1_0_0_0_0_0;
      else     e = {~s | b, ~s, b, s | b, 5'b0};
    end else begin
      ph = m_q[0];
      e  = {ph == "L", 3'b111, ph == "P", ph == "F",
            ph == "L", 1'b1, ph == "L"};
    end
    chk("ctrl", {55'd0, pcw, en, f1, f2, ppc, pfl, lv, busy, ack},
        {55'd0, e});
    chk("ret_pc", {32'd0, ret}, {32'd0, m_ret});
    busy_cnt += int'(busy);
    ppc_cnt  += int'(ppc);
    lv_cnt   += int'(lv | ack);
    @(posedge clk);
    if (r) begin
      m_q.delete();
      m_pend = 1'b0;
      m_prev = 1'b0;
      m_ret  = '0;
    end else begin
      m_prev = q;
      if (m_q.size() == 0) begin
        m_pend = pend & ~acc;
        if (acc) begin
          m_ret = p;
          for (int i = 0; i < N; i++) m_q.push_back("D");
          m_q.push_back("P");
          m_q.push_back("F");
          m_q.push_back("L");
        end
      end else begin
        m_pend = pend;
        ph = m_q[0];
        if (!((ph == "P" || ph == "F") && m)) void'(m_q.pop_front());
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 32'h100 + i);
  endtask

  initial begin
    rst = 1; stall = 0; br = 0; req = 0; mbusy = 0; pc = 0;
    busy_cnt = 0; ppc_cnt = 0; lv_cnt = 0;

    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    idle(2);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);

    busy_cnt = 0;
    step(0, 0, 0, 1, 0, 32'h40);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 32'h44);
    chk("busy_len", busy_cnt, 6);
    chk("ret_0x40", {32'd0, ret}, 64'h40);

    step(0, 1, 0, 1, 0, 32'h50);
    step(0, 1, 0, 1, 0, 32'h54);
    step(0, 0, 1, 0, 0, 32'h58);
    step(0, 0, 0, 0, 0, 32'h5c);
    chk("ret_defer", {32'd0, ret}, 64'h5c);
    idle(8);

    ppc_cnt = 0; busy_cnt = 0;
    step(0, 0, 0, 1, 0, 32'h80);
    for (int i = 0; i < N; i++) step(0, 0, 0, 0, 0, 32'h84);
    step(0, 0, 0, 0, 1, 32'h84);
    step(0, 0, 0, 0, 1, 32'h84);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 32'h84);
    chk("ppc_len", ppc_cnt, 3);
    chk("busy_stretch", busy_cnt, 8);

    lv_cnt = 0;
    step(0, 0, 0, 1, 0, 32'hA0);
    step(0, 0, 0, 0, 0, 32'hA4);
    step(0, 0, 0, 1, 0, 32'hA8);
    step(0, 0, 0, 0, 0, 32'hAC);
    step(0, 0, 0, 0, 0, 32'hB0);
    step(1, 0, 0, 0, 0, 32'hB4);
    idle(10);
    chk("rst_abandon", lv_cnt, 0);
    chk("rst_ret", {32'd0, ret}, 64'h0);

    busy_cnt = 0;
    step(0, 0, 0, 1, 0, 32'hC0);
    step(0, 0, 0, 0, 0, 32'hC4);
    step(0, 0, 0, 1, 0, 32'hC8);
    for (int i = 0; i < 14; i++) step(0, 0, 0, 0, 0, 32'hD0 + i);
    chk("two_ints", busy_cnt, 12);

    for (int i = 0; i < 800; i++)
      step($urandom_range(63) == 0, $urandom_range(3) == 0,
           $urandom_range(5) == 0, $urandom_range(7) < 3,
           $urandom_range(2) == 0, $urandom);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
